// File: rtl/ahb_apb_bridge_if.sv
// rtl/ahb_apb_bridge_if.sv - AHB-lite slave / dual APB master signal bundle
interface ahb_apb_bridge_if;
  logic       hsel;
  logic [1:0] htrans;
  logic       hwrite;
  logic [8:0] haddr;
  logic [7:0] hwdata;
  logic [7:0] hrdata;
  logic       hready_out;
  logic       hresp;
  logic       psel1;
  logic       psel2;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic       pready1;
  logic       pready2;
  logic [7:0] prdata1;
  logic [7:0] prdata2;

  modport slave (
    input  hsel, htrans, hwrite, haddr, hwdata, pready1, pready2, prdata1, prdata2,
    output hrdata, hready_out, hresp, psel1, psel2, penable, pwrite, paddr, pwdata
  );

  modport master (
    output hsel, htrans, hwrite, haddr, hwdata, pready1, pready2, prdata1, prdata2,
    input  hrdata, hready_out, hresp, psel1, psel2, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - AHB-lite slave to dual-slave APB master bridge
module ahb_apb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic             pclk,
    input logic             preset,
    ahb_apb_bridge_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
`ifdef APB_TIMEOUT_EN
        , S_ERR1,
        S_ERR2
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] addr_q, addr_d;
    logic       write_q, write_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;

    logic       hready;
    logic       psel_any;
    logic       penable;
    logic       accept;
    logic       sel_ready;
    logic [7:0] sel_rdata;
    logic       unused_htrans0;

    assign unused_htrans0 = bus.htrans[0];
    assign accept    = bus.hsel & bus.htrans[1] & hready;
    assign sel_ready = addr_q[8] ? bus.pready2 : bus.pready1;
    assign sel_rdata = addr_q[8] ? bus.prdata2 : bus.prdata1;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_hit;
    logic       hresp;

    assign timeout_hit = !sel_ready && (cnt_q + 8'd1 == TIMEOUT_LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_SETUP)
            cnt_d = 8'd0;
        else if (state_q == S_ACCESS && !sel_ready)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end
`endif

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                if (sel_ready) state_d = S_IDLE;
`ifdef APB_TIMEOUT_EN
                else if (timeout_hit) state_d = S_ERR1;
`endif
            end
`ifdef APB_TIMEOUT_EN
            S_ERR1:   state_d = S_ERR2;
            S_ERR2:   state_d = accept ? S_SETUP : S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hready   = 1'b0;
        psel_any = 1'b0;
        penable  = 1'b0;
`ifdef APB_TIMEOUT_EN
        hresp    = 1'b0;
`endif
        case (state_q)
            S_IDLE:   hready = 1'b1;
            S_SETUP:  psel_any = 1'b1;
            S_ACCESS: begin
                psel_any = 1'b1;
                penable  = 1'b1;
            end
`ifdef APB_TIMEOUT_EN
            S_ERR1:   hresp = 1'b1;
            S_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
`endif
            default:  hready = 1'b1;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (accept) begin
            addr_d  = bus.haddr;
            write_d = bus.hwrite;
        end
        if (state_q == S_SETUP && write_q)
            wdata_d = bus.hwdata;
        if (state_q == S_ACCESS && sel_ready && !write_q)
            rdata_d = sel_rdata;
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            addr_q  <= 9'd0;
            write_q <= 1'b0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.psel1      = psel_any & ~addr_q[8];
    assign bus.psel2      = psel_any &  addr_q[8];
    assign bus.penable    = penable;
    assign bus.pwrite     = write_q;
    assign bus.paddr      = addr_q[7:0];
    assign bus.pwdata     = wdata_q;
    assign bus.hrdata     = rdata_q;
    assign bus.hready_out = hready;
`ifdef APB_TIMEOUT_EN
    assign bus.hresp      = hresp;
`else
    assign bus.hresp      = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - self-checking bench for ahb_apb_bridge
module tb_ahb_apb_bridge;

    localparam int H = 38;

    typedef struct {
        int         s;
        bit         wr;
        logic [8:0] a;
        logic [7:0] wd;
        int         w;
        logic [7:0] rd;
    } txn_t;

    typedef struct {
        logic       hsel;
        logic [1:0] htrans;
        logic       hwrite;
        logic [8:0] haddr;
        logic [7:0] hwdata;
        logic       pready1;
        logic       pready2;
        logic [7:0] prdata1;
        logic [7:0] prdata2;
    } stim_t;

    typedef struct {
        logic       psel1;
        logic       psel2;
        logic       penable;
        logic       pwrite;
        logic       hready;
        logic [7:0] paddr;
        logic [7:0] pwdata;
        logic [7:0] hrdata;
    } exp_t;

    logic pclk;
    logic preset;
    ahb_apb_bridge_if ifc ();

    ahb_apb_bridge #(.TIMEOUT_CYCLES(4)) u_dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (ifc)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    bit    chk_en = 0;
    int    low_cnt = 0;
    txn_t  txns [7];
    stim_t stim [H];
    exp_t  expv [H];

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input stim_t st);
        ifc.hsel    = st.hsel;
        ifc.htrans  = st.htrans;
        ifc.hwrite  = st.hwrite;
        ifc.haddr   = st.haddr;
        ifc.hwdata  = st.hwdata;
        ifc.pready1 = st.pready1;
        ifc.pready2 = st.pready2;
        ifc.prdata1 = st.prdata1;
        ifc.prdata2 = st.prdata2;
    endtask

    task automatic build_model();
        logic [7:0] last_addr, last_wdata, last_rdata;
        logic       last_wr, act, a8;
        for (int c = 0; c < H; c++) begin
            stim[c].hsel    = (c % 4 == 1) || (c % 4 == 2);
            stim[c].htrans  = (c % 4 == 0) ? 2'b10 : (c % 4 == 1) ? 2'b00 : (c % 4 == 2) ? 2'b01 : 2'b11;
            stim[c].hwrite  = 1'b1;
            stim[c].haddr   = 9'h1EE;
            stim[c].hwdata  = 8'hFF;
            stim[c].pready1 = 1'b1;
            stim[c].pready2 = 1'b1;
            stim[c].prdata1 = 8'hEE;
            stim[c].prdata2 = 8'hDD;
        end
        foreach (txns[i]) begin
            for (int c = txns[i].s + 1; c < txns[i].s + 3 + txns[i].w; c++) begin
                stim[c].hsel   = 1'b1;
                stim[c].htrans = 2'b10;
                stim[c].haddr  = 9'h1EE;
            end
        end
        foreach (txns[i]) begin
            stim[txns[i].s].hsel   = 1'b1;
            stim[txns[i].s].htrans = 2'b10;
            stim[txns[i].s].hwrite = txns[i].wr;
            stim[txns[i].s].haddr  = txns[i].a;
            for (int c = txns[i].s + 1; c <= txns[i].s + 3 + txns[i].w; c++)
                stim[c].hwdata = txns[i].wr ? txns[i].wd : 8'h0F;
            for (int k = 0; k <= txns[i].w; k++) begin
                if (txns[i].a[8]) begin
                    stim[txns[i].s + 2 + k].pready2 = (k == txns[i].w);
                    stim[txns[i].s + 2 + k].prdata2 = (k == txns[i].w) ? txns[i].rd : 8'h11;
                end else begin
                    stim[txns[i].s + 2 + k].pready1 = (k == txns[i].w);
                    stim[txns[i].s + 2 + k].prdata1 = (k == txns[i].w) ? txns[i].rd : 8'h11;
                end
            end
        end
        last_addr = 8'h00; last_wdata = 8'h00; last_rdata = 8'h00; last_wr = 1'b0;
        for (int c = 0; c < H; c++) begin
            act = 1'b0; a8 = 1'b0; expv[c].penable = 1'b0;
            foreach (txns[i]) begin
                if (c == txns[i].s + 1) begin
                    act = 1'b1; a8 = txns[i].a[8];
                    last_addr = txns[i].a[7:0]; last_wr = txns[i].wr;
                end
                if (c >= txns[i].s + 2 && c <= txns[i].s + 2 + txns[i].w) begin
                    act = 1'b1; a8 = txns[i].a[8]; expv[c].penable = 1'b1;
                    if (c == txns[i].s + 2 && txns[i].wr) last_wdata = txns[i].wd;
                end
                if (c == txns[i].s + 3 + txns[i].w && !txns[i].wr) last_rdata = txns[i].rd;
            end
            expv[c].psel1  = act & ~a8;
            expv[c].psel2  = act & a8;
            expv[c].hready = ~act;
            expv[c].pwrite = last_wr;
            expv[c].paddr  = last_addr;
            expv[c].pwdata = last_wdata;
            expv[c].hrdata = last_rdata;
        end
    endtask

    always @(negedge pclk) begin
        if (chk_en) begin
            check($sformatf("psel1@%0d", cyc),   ifc.psel1,      expv[cyc].psel1);
            check($sformatf("psel2@%0d", cyc),   ifc.psel2,      expv[cyc].psel2);
            check($sformatf("penable@%0d", cyc), ifc.penable,    expv[cyc].penable);
            check($sformatf("pwrite@%0d", cyc),  ifc.pwrite,     expv[cyc].pwrite);
            check($sformatf("paddr@%0d", cyc),   ifc.paddr,      expv[cyc].paddr);
            check($sformatf("pwdata@%0d", cyc),  ifc.pwdata,     expv[cyc].pwdata);
            check($sformatf("hrdata@%0d", cyc),  ifc.hrdata,     expv[cyc].hrdata);
            check($sformatf("hready@%0d", cyc),  ifc.hready_out, expv[cyc].hready);
            check($sformatf("hresp@%0d", cyc),   ifc.hresp,      1'b0);
            if (cyc >= 18 && cyc <= 24 && ifc.hready_out === 1'b0) low_cnt++;
            case (cyc)
                4:  begin check("lit_paddr_wr", ifc.paddr, 8'h03); check("lit_pwdata_wr", ifc.pwdata, 8'h5A); end
                10: check("lit_hrdata_rd", ifc.hrdata, 8'hC3);
                13: check("lit_hrdata_after_wr", ifc.hrdata, 8'hC3);
                14: check("lit_b2b_setup_paddr", ifc.paddr, 8'h45);
                16: begin check("lit_b2b_pwdata", ifc.pwdata, 8'h3C); check("lit_b2b_hrdata", ifc.hrdata, 8'h99); end
                25: check("lit_wait3_low_cycles", low_cnt[15:0], 16'd5);
                35: check("lit_hrdata_slave1", ifc.hrdata, 8'hE1);
                default: ;
            endcase
        end
    end

    initial begin
        int   n;
        logic [3:0] to_exp [8];
        txns = '{
            '{2,  1'b1, 9'h003, 8'h5A, 0, 8'h55},
            '{7,  1'b0, 9'h103, 8'h00, 0, 8'hC3},
            '{10, 1'b1, 9'h1A0, 8'h3C, 0, 8'h55},
            '{13, 1'b0, 9'h045, 8'h00, 0, 8'h99},
            '{18, 1'b1, 9'h0F0, 8'hA5, 3, 8'h55},
            '{26, 1'b0, 9'h1FF, 8'h00, 1, 8'h7E},
            '{30, 1'b0, 9'h010, 8'h00, 2, 8'hE1}
        };
        build_model();
        preset = 1'b0;
        apply(stim[0]);
        #12;
        check("rst_psel1", ifc.psel1, 1'b0);
        check("rst_psel2", ifc.psel2, 1'b0);
        check("rst_penable", ifc.penable, 1'b0);
        check("rst_pwrite", ifc.pwrite, 1'b0);
        check("rst_paddr", ifc.paddr, 8'h00);
        check("rst_pwdata", ifc.pwdata, 8'h00);
        check("rst_hrdata", ifc.hrdata, 8'h00);
        check("rst_hready", ifc.hready_out, 1'b1);
        check("rst_hresp", ifc.hresp, 1'b0);
        @(negedge pclk);
        preset = 1'b1;

        for (int c = 0; c < H; c++) begin
            @(posedge pclk); #1;
            apply(stim[c]);
            cyc = c;
            chk_en = 1'b1;
        end
        @(posedge pclk); #1;
        chk_en = 1'b0;

        ifc.hsel = 1'b1; ifc.htrans = 2'b10; ifc.hwrite = 1'b1; ifc.haddr = 9'h022;
        ifc.pready1 = 1'b0; ifc.pready2 = 1'b1;
        @(posedge pclk); #1;
        ifc.hsel = 1'b0; ifc.htrans = 2'b00; ifc.hwdata = 8'h77;
        @(posedge pclk); #1;
        check("arst_pre_penable", ifc.penable, 1'b1);
        check("arst_pre_pwdata", ifc.pwdata, 8'h77);
        #2 preset = 1'b0;
        #1;
        check("arst_psel1", ifc.psel1, 1'b0);
        check("arst_penable", ifc.penable, 1'b0);
        check("arst_hready", ifc.hready_out, 1'b1);
        check("arst_paddr", ifc.paddr, 8'h00);
        check("arst_pwdata", ifc.pwdata, 8'h00);
        check("arst_hrdata", ifc.hrdata, 8'h00);
        @(negedge pclk);
        preset = 1'b1;

        @(posedge pclk); #1;
        ifc.hsel = 1'b1; ifc.htrans = 2'b10; ifc.hwrite = 1'b0; ifc.haddr = 9'h155;
        ifc.pready2 = 1'b1; ifc.prdata2 = 8'h6B; ifc.pready1 = 1'b0;
        @(posedge pclk); #1;
        ifc.hsel = 1'b0; ifc.htrans = 2'b00;
        check("post_psel2", ifc.psel2, 1'b1);
        check("post_psel1", ifc.psel1, 1'b0);
        check("post_paddr", ifc.paddr, 8'h55);
        n = 0;
        while (ifc.hready_out !== 1'b1 && n < 20) begin
            @(posedge pclk); #1;
            n++;
        end
        check("post_low_cycles", n[15:0], 16'd2);
        check("post_hrdata", ifc.hrdata, 8'h6B);

`ifdef APB_TIMEOUT_EN
        to_exp = '{4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0001, 4'b0011, 4'b0010};
        ifc.hsel = 1'b1; ifc.htrans = 2'b10; ifc.hwrite = 1'b0; ifc.haddr = 9'h040;
        ifc.pready1 = 1'b0; ifc.prdata1 = 8'h99;
        @(posedge pclk); #1;
        ifc.hsel = 1'b0; ifc.htrans = 2'b00;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("tmo_flags_%0d", k),
                  {ifc.psel1, ifc.penable, ifc.hready_out, ifc.hresp}, to_exp[k]);
            @(posedge pclk); #1;
        end
        check("tmo_hrdata_kept", ifc.hrdata, 8'h6B);
`else
        to_exp = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
        check("idle_flags", {ifc.psel1, ifc.penable, ifc.hready_out, ifc.hresp}, 4'b0010 | to_exp[0]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
